// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: tick prescaler, switch debounce, four-mode LED driver
// (off / on / per-channel blink / PWM breathing), heartbeat and PMOD debug bus.
// state        | meaning
// MODE_OFF     | all LEDs dark
// MODE_ON      | all LEDs lit
// MODE_BLINK   | channel i toggles every BLINK_TICKS*(i+1) ticks
// MODE_BREATHE | PWM breathing, odd channels in antiphase
module led_pattern_ctrl #(
  parameter int CLK_HZ          = 60000000,
  parameter int TICK_HZ         = 1000,
  parameter int CHANNELS        = 2,
  parameter int DEBOUNCE_TICKS  = 20,
  parameter int BLINK_TICKS     = 500,
  parameter int PWM_BITS        = 8,
  parameter int HEARTBEAT_TICKS = 500
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sw,
  output logic [CHANNELS-1:0] led,
  output logic                heartbeat,
  output logic [1:0]          mode,
  output logic                tick,
  output logic [7:0]          dbg
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = $clog2(DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam int BLK_W = $clog2(BLINK_TICKS * CHANNELS + 1);
  localparam int HB_W  = $clog2(HEARTBEAT_TICKS + 1);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [DEB_W-1:0]    DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [HB_W-1:0]     HB_LAST  = HB_W'(HEARTBEAT_TICKS - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  mode_t               mode_q, mode_d;
  logic [PRE_W-1:0]    pre_cnt;
  logic                sync1, sync2;
  logic                sw_stable, sw_stable_d;
  logic [DEB_W-1:0]    deb_cnt;
  logic                press;
  logic [HB_W-1:0]     hb_cnt;
  logic [PWM_BITS-1:0] pwm_cnt, duty;
  logic                dir_down;
  logic [CHANNELS-1:0] blink_led, led_d;
  logic [2:0]          led3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
      tick    <= (pre_cnt == PRE_LAST);
    end
  end

  // Only a change that persists for DEBOUNCE_TICKS consecutive ticks is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sw_stable   <= 1'b0;
      sw_stable_d <= 1'b0;
      deb_cnt     <= '0;
    end else begin
      sync1       <= sw;
      sync2       <= sync1;
      sw_stable_d <= sw_stable;
      if (tick) begin
        if (sync2 == sw_stable) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
          sw_stable <= sync2;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end
  end

  assign press = sw_stable & ~sw_stable_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= MODE_OFF;
    else        mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (press) mode_d = mode_t'(2'(mode_q + 2'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else if (tick) begin
      if (hb_cnt == HB_LAST) begin
        hb_cnt    <= '0;
        heartbeat <= ~heartbeat;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end
  end

  // Duty triangle ramp; a mode change restarts it from zero going up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      duty     <= '0;
      dir_down <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (press) begin
        duty     <= '0;
        dir_down <= 1'b0;
      end else if (tick) begin
        if (!dir_down) begin
          if (duty == PWM_MAX) begin
            dir_down <= 1'b1;
            duty     <= duty - 1'b1;
          end else begin
            duty <= duty + 1'b1;
          end
        end else begin
          if (duty == '0) begin
            dir_down <= 1'b0;
            duty     <= duty + 1'b1;
          end else begin
            duty <= duty - 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_blink
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS * (g + 1) - 1);
    logic [BLK_W-1:0] blink_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        blink_cnt    <= '0;
        blink_led[g] <= 1'b0;
      end else if (press) begin
        blink_cnt    <= '0;
        blink_led[g] <= 1'b0;
      end else if (tick) begin
        if (blink_cnt == BLK_LAST) begin
          blink_cnt    <= '0;
          blink_led[g] <= ~blink_led[g];
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_ON:    led_d = '1;
      MODE_BLINK: led_d = blink_led;
      MODE_BREATHE: begin
        for (int i = 0; i < CHANNELS; i++)
          led_d[i] = (i % 2 == 0) ? (pwm_cnt < duty) : (pwm_cnt < PWM_MAX - duty);
      end
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= '0;
    else        led <= led_d;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dbg
    if (g < CHANNELS) begin : g_used
      assign led3[g] = led[g];
    end else begin : g_pad
      assign led3[g] = 1'b0;
    end
  end

  assign mode = mode_q;
  assign dbg  = {mode_q, sw_stable, tick, heartbeat, led3};

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed and random switch activity compared every
// cycle against an elapsed-cycle / elapsed-tick reference model.
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw = 1'b0;
  logic [1:0] led;
  logic       heartbeat;
  logic [1:0] mode;
  logic       tick;
  logic [7:0] dbg;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .CLK_HZ(100), .TICK_HZ(10), .CHANNELS(2), .DEBOUNCE_TICKS(3),
    .BLINK_TICKS(4), .PWM_BITS(4), .HEARTBEAT_TICKS(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .led(led), .heartbeat(heartbeat),
    .mode(mode), .tick(tick), .dbg(dbg)
  );

  // Reference model: clocks since release, ticks total, ticks since mode entry.
  int         m_n, m_tick, m_s1, m_s2, m_stable, m_stable_d, m_run, m_mode, m_t, m_tc;
  int         m_press;
  logic [1:0] m_led, m_led_nx;

  function automatic int tri_duty(int tt);
    int p;
    p = tt % 30;
    return (p <= 15) ? p : 30 - p;
  endfunction

  function automatic logic [1:0] led_fn(int md, int tt, int nn);
    int d, p;
    logic [1:0] r;
    r = 2'b00;
    d = tri_duty(tt);
    p = nn % 16;
    case (md)
      1: r = 2'b11;
      2: r = {((tt / 8) % 2) == 1, ((tt / 4) % 2) == 1};
      3: r = {p < 15 - d, p < d};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_tick = 0; m_s1 = 0; m_s2 = 0; m_stable = 0; m_stable_d = 0;
      m_run = 0; m_mode = 0; m_t = 0; m_tc = 0; m_led = 2'b00;
    end else begin
      m_led_nx   = led_fn(m_mode, m_t, m_n);
      m_press    = (m_stable == 1 && m_stable_d == 0) ? 1 : 0;
      m_stable_d = m_stable;
      if (m_tick == 1) begin
        m_tc = m_tc + 1;
        if (m_s2 != m_stable) begin
          m_run = m_run + 1;
          if (m_run == 3) begin
            m_stable = m_s2;
            m_run    = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      if (m_press == 1) begin
        m_mode = (m_mode + 1) % 4;
        m_t    = 0;
      end else if (m_tick == 1) begin
        m_t = m_t + 1;
      end
      m_s2   = m_s1;
      m_s1   = sw ? 1 : 0;
      m_n    = m_n + 1;
      m_tick = (m_n % 10 == 0) ? 1 : 0;
      m_led  = m_led_nx;
    end
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all();
    logic [1:0] md;
    logic       hb, st, tk;
    md = 2'(m_mode);
    hb = ((m_tc / 5) % 2) == 1;
    st = (m_stable == 1);
    tk = (m_tick == 1);
    chk("led", 8'(led), 8'(m_led));
    chk("mode", 8'(mode), 8'(md));
    chk("tick", 8'(tick), 8'(tk));
    chk("heartbeat", 8'(heartbeat), 8'(hb));
    chk("dbg", dbg, {md, st, tk, hb, 1'b0, m_led});
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic press_once();
    sw = 1'b1;
    run(50);
    sw = 1'b0;
    run(50);
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = 1'b0;
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    run(120);

    // bounce of two ticks must be rejected
    sw = 1'b1;
    run(20);
    sw = 1'b0;
    run(60);
    chk("mode_after_bounce", 8'(mode), 8'd0);

    // four clean presses wrap back to OFF
    for (int k = 0; k < 4; k++) press_once();
    chk("mode_after_wrap", 8'(mode), 8'd0);

    // BLINK, then BREATHE through more than a full ramp
    press_once();
    press_once();
    run(200);
    chk("mode_blink", 8'(mode), 8'd2);
    press_once();
    run(350);
    chk("mode_breathe", 8'(mode), 8'd3);

    // random switch activity including sub-debounce glitches
    for (int k = 0; k < 40; k++) begin
      sw = 1'($urandom_range(0, 1));
      run(int'($urandom_range(1, 60)));
    end
    sw = 1'b0;
    run(60);

    // get back to BLINK, start a press, then reset in the middle of it
    for (int k = 0; k < 4 && m_mode != 2; k++) press_once();
    run(30);
    sw = 1'b1;
    run(15);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sw    = 1'b0;
    #1;
    chk("async_led", 8'(led), 8'd0);
    chk("async_mode", 8'(mode), 8'd0);
    chk("async_dbg", dbg, 8'd0);
    chk("async_hb", 8'(heartbeat), 8'd0);
    run(3);
    rst_n = 1'b1;
    run(150);
    chk("mode_after_reset", 8'(mode), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
